data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for CPU data loads and stores. It accepts one word or byte access at a time over a req/ready handshake and services it after a fixed, parameterised latency. The result comes back with a one-cycle response strobe. The block replaces the zero-latency data RAM so the core and its bus logic can be exercised against a memory with wait states.

## Interface
- DW, 32, data and address width
- AW, 12, byte-address bits actually decoded; memory depth is 2^AW bytes
- LATENCY, 2, clock edges from request acceptance to response; legal range 1..15
- INIT_FILE, "", hex file loaded at elaboration; empty string means no preload
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_i  input  1  access request; sampled only while ready_o=1
- we_i  input  1  1 = store, 0 = load
- size_i  input  1  0 = word access, 1 = byte access
- addr_i  input  DW  byte address
- wdata_i  input  DW  store data; byte stores use bits [7:0]
- ready_o  output  1  responder idle, can accept a request this cycle
- rvalid_o  output  1  one-cycle response strobe, for both loads and stores
- rdata_o  output  DW  load result, valid while rvalid_o=1

## Operation
- FSM states: BOOT, IDLE, WAIT, RESP.
  - Reset enters BOOT.
  - BOOT goes to IDLE on the first edge after rst_n rises.
- IDLE:
  - ready_o=1.
  - On an edge with req_i=1, capture we_i, size_i, addr_i[AW-1:0] and wdata_i.
  - Load the countdown with LATENCY-1 and go to WAIT.
  - req_i=0 stays in IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0, perform the access and go to RESP.
  - Store: memory is updated on that edge.
  - Load: rdata_o is registered on that edge.
- RESP:
  - rvalid_o=1 for exactly one cycle, then return to IDLE.
  - No back-pressure; the requester must take the response.
- Addressing:
  - Little-endian byte array.
  - Address bits above AW are ignored, so addresses wrap modulo 2^AW.
  - Word accesses force addr[1:0]=0.
  - Word store writes 4 bytes.
  - Byte store writes only the addressed byte.
  - Byte load returns the byte zero-extended to DW.
- Store response:
  - rdata_o is held at its previous value; the requester must ignore it.
- req_i while ready_o=0 is ignored; it is not queued.
- Reset mid-access:
  - FSM returns to BOOT and the counter clears.
  - A pending store that has not reached its access edge is discarded.
  - Memory contents are never reset.

## Timing
- Reset values: ready_o=0, rvalid_o=0, rdata_o=0.
- ready_o rises one edge after reset release.
- ready_o and rvalid_o are decoded directly from the state register (glitch-free, no input paths).
- Request accepted at edge T:
  - Access happens at edge T+LATENCY.
  - rvalid_o is high in the cycle after T+LATENCY.
  - ready_o is high again after edge T+LATENCY+1.
- Throughput: one access per LATENCY+2 cycles. With LATENCY=2 there are 4 cycles per access.
- A load immediately following a store to the same address returns the stored data, because the store commits before RESP.

## Structure
- Package mem_pkg:
  - State enum: BOOT, IDLE, WAIT, RESP.
  - Size encodings: SIZE_WORD=1'b0, SIZE_BYTE=1'b1.
  - LATENCY counter width constant: 4 bits.
- Sub-module mem_byte_array holds the 2^AW x 8 storage and the INIT_FILE preload.
  - Write port: byte-enable[3:0], word-aligned address, 32-bit data.
  - Read port: registered, enabled by the responder at the access edge.
- The top-level responder holds the FSM, the capture registers, the countdown and the byte-lane select/zero-extend logic.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release; req_i=0.
  - Response: ready_o=0 and rvalid_o=0 during reset; ready_o=1 from the second cycle after release.
- Word store then load, LATENCY=2:
  - Stimulus: store 0xDEADBEEF to address 0x010, then load from 0x010.
  - Response: each rvalid_o pulse comes 2 edges after acceptance; the load returns 0xDEADBEEF.
- Byte store/load, aligned word:
  - Stimulus: byte store 0xA5 to 0x011 over the word 0x11223344 at 0x010.
  - Response: word load of 0x010 returns 0x1122A544; byte load of 0x011 returns 0x000000A5.
- Misalignment and wrap:
  - Stimulus (a): word load of 0x013. Response: returns the word at 0x010.
  - Stimulus (b): load of 0x1010 with AW=12. Response: aliases to 0x010.
- Ignored request:
  - Stimulus: hold req_i=1 continuously with a different address each cycle.
  - Response: only addresses presented while ready_o=1 are accepted, one per 4 cycles; no extra rvalid_o pulses.
- Reset mid-store:
  - Stimulus: store 0xCAFEF00D to 0x020 (previously 0x0), then assert rst_n=0 one cycle after acceptance; after recovery, load 0x020.
  - Response: ready_o and rvalid_o drop immediately; the load returns 0x00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state, size encodings and helpers for the data memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Wide enough for LATENCY-1 with LATENCY up to 15
    localparam int CNT_W = 4;

    // Byte lanes touched by an access: all four for a word, one for a byte
    function automatic logic [3:0] byte_en(input logic size, input logic [1:0] lane);
        return (size == SIZE_BYTE) ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: 2^AW x 8 little-endian storage with byte-enabled writes and a registered word read
module mem_byte_array #(
  parameter int AW        = 12,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);
  logic [7:0]  mem_q [2**AW];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we_i && be_i[i]) mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= {mem_q[addr_i + AW'(3)], mem_q[addr_i + AW'(2)],
                               mem_q[addr_i + AW'(1)], mem_q[addr_i]};
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder over a req/ready handshake
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 12,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic          we_i,
    input  logic          size_i,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          ready_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, size_q, lbyte_q;
    logic [AW-1:0]    addr_q, word_addr;
    logic [31:0]      wdata_q, arr_wdata, word;
    logic [1:0]       lsel_q;
    logic             accept, access;
    logic             unused_addr;

    assign accept      = (state_q == IDLE) && req_i;
    assign access      = (state_q == WAIT) && (cnt_q == '0);
    assign word_addr   = {addr_q[AW-1:2], 2'b00};
    assign arr_wdata   = (size_q == SIZE_BYTE) ? {4{wdata_q[7:0]}} : wdata_q;
    assign unused_addr = ^addr_i[DW-1:AW];

    // Next state and countdown; the access happens on the edge the count reads zero
    always_comb begin
        state_d = (state_q == BOOT) ? IDLE :
                  (state_q == IDLE) ? (req_i ? WAIT : IDLE) :
                  (state_q == WAIT) ? ((cnt_q == '0) ? RESP : WAIT) : IDLE;
        cnt_d   = accept ? CNT_W'(LATENCY - 1) :
                  ((state_q == WAIT) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
    end

    // FSM and countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on acceptance; lane select latched only by loads so stores leave rdata_o untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= SIZE_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            lsel_q  <= '0;
            lbyte_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                addr_q  <= addr_i[AW-1:0];
                wdata_q <= wdata_i[31:0];
            end
            if (access && !we_q) begin
                lsel_q  <= addr_q[1:0];
                lbyte_q <= (size_q == SIZE_BYTE);
            end
        end
    end

    mem_byte_array #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (word_addr),
        .we_i    (access && we_q),
        .be_i    (byte_en(size_q, addr_q[1:0])),
        .wdata_i (arr_wdata),
        .re_i    (access && !we_q),
        .rdata_o (word)
    );

    assign ready_o  = (state_q == IDLE);
    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = lbyte_q ? DW'((word >> {lsel_q, 3'b000}) & 32'h0000_00FF) : DW'(word);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven checks of the data memory responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic        size_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, rvalid_o;
    logic [31:0] rdata_o;

    int total = 0;
    int bad = 0;

    data_mem_responder #(.DW(32), .AW(12), .LATENCY(2), .INIT_FILE("")) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .we_i     (we_i),
        .size_i   (size_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Starts at a negedge, ends at a negedge with the responder idle again
    task automatic access(input logic we, input logic size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd);
        int w = 0;
        int lat = 0;
        while (!ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", {31'b0, ready_o}, 32'd1);
        req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
        @(posedge clk);
        #1 req_i = 1'b0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rvalid_o && lat < 20);
        chk("latency", lat, 32'd2);
        rd = rdata_o;
        @(posedge clk);
        #1;
        chk("rvalid_drop", {31'b0, rvalid_o}, 32'd0);
        chk("ready_back", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] seen[$];

        tv[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        tv[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tv[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF};
        tv[3]  = '{1'b1, 1'b1, 32'h0000_0011, 32'h0000_00A5, 32'hDEAD_BEEF};
        tv[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1122_A544};
        tv[5]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_00A5};
        tv[6]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h1122_A544};
        tv[7]  = '{1'b0, 1'b0, 32'h0000_1010, 32'h0,         32'h1122_A544};
        tv[8]  = '{1'b0, 1'b1, 32'h0000_1012, 32'h0,         32'h0000_0022};
        tv[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0022};
        tv[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000};
        tv[11] = '{1'b1, 1'b1, 32'h0000_0023, 32'hFFFF_FF7F, 32'h0000_0000};
        tv[12] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h7F00_0000};
        tv[13] = '{1'b0, 1'b1, 32'h0000_1023, 32'h0,         32'h0000_007F};
        tv[14] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0102_0304, 32'h0000_007F};
        tv[15] = '{1'b0, 1'b1, 32'h0000_0FFF, 32'h0,         32'h0000_0001};

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, ready_o}, 32'd0);
        chk("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        #1 chk("boot_ready", {31'b0, ready_o}, 32'd0);
        @(negedge clk);
        chk("idle_ready", {31'b0, ready_o}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            access(tv[i].we, tv[i].size, tv[i].addr, tv[i].wdata, rd);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp);
        end

        for (int i = 0; i < 16; i++)
            access(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hB000_0000 | 32'(i), rd);

        for (int c = 0; c < 20; c++) begin
            if (rvalid_o) seen.push_back(rdata_o);
            if (c < 16) begin
                req_i = 1'b1; we_i = 1'b0; size_i = 1'b0; addr_i = 32'h100 + 32'(4 * c);
            end else req_i = 1'b0;
            @(negedge clk);
        end
        chk("busy_req_pulses", seen.size(), 32'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk($sformatf("busy_req_data%0d", k), seen[k], 32'hB000_0000 | 32'(4 * k));

        access(1'b1, 1'b0, 32'h20, 32'h0, rd);
        access(1'b0, 1'b0, 32'h10, 32'h0, rd);
        chk("pre_reset_load", rd, 32'h1122_A544);
        req_i = 1'b1; we_i = 1'b1; size_i = 1'b0; addr_i = 32'h20; wdata_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", {31'b0, ready_o}, 32'd0);
        chk("midreset_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("midreset_rdata", rdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("recover_ready", {31'b0, ready_o}, 32'd1);
        access(1'b0, 1'b0, 32'h20, 32'h0, rd);
        chk("discarded_store", rd, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
